// File: rtl/bitstream_loader_pkg.sv
// Shared types and constants for the serial configuration-chain loader.
// Optional readback is enabled with the BITSTREAM_LOADER_READBACK_EN macro.
package bitstream_loader_pkg;

    // Loader control states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SETUP = 3'd2,
        PULSE = 3'd3,
        FALL  = 3'd4,
        DONE  = 3'd5
    } state_t;

    // clk cycles spent on each chain bit: SETUP, PULSE, FALL
    localparam int unsigned PHASES_PER_BIT = 3;

    // Number of words needed to fill a chain
    function automatic int unsigned words_per_load(input int unsigned chain_len,
                                                   input int unsigned word_w);
        return (chain_len + word_w - 1) / word_w;
    endfunction

    // clk cycles from LOAD entry to DONE with no input stalls
    function automatic int unsigned load_cycles(input int unsigned chain_len,
                                                input int unsigned word_w);
        return words_per_load(chain_len, word_w) + PHASES_PER_BIT * chain_len;
    endfunction

endpackage

// File: rtl/bitstream_loader_serializer.sv
// Word register, bit counters and optional readback shifter for the loader.
// Readback logic exists only when BITSTREAM_LOADER_READBACK_EN is defined.
module loader_serializer
    import bitstream_loader_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = 24,
    parameter int unsigned WORD_W    = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_load,
    input  logic [WORD_W-1:0] i_data,
    input  logic              i_advance,
    input  logic              i_capture,
    input  logic              i_prog_out,
    output logic              o_next_bit_c,
    output logic              o_word_last_c,
    output logic              o_chain_last_c,
    output logic [WORD_W-1:0] o_rb_data,
    output logic              o_rb_valid
);

    localparam int unsigned CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int unsigned POS_W = $clog2(WORD_W + 1);

    logic [WORD_W-1:0] r_word;
    logic [CNT_W-1:0]  r_chain_idx;
    logic [POS_W-1:0]  r_word_pos;

    // Bit 0 goes straight from the bus; later bits come from the remaining-bits register
    assign o_next_bit_c   = i_load ? i_data[0] : r_word[0];
    assign o_word_last_c  = (r_word_pos == POS_W'(WORD_W - 1));
    assign o_chain_last_c = (r_chain_idx == CNT_W'(CHAIN_LEN - 1));

    // Remaining word bits and position counters
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_word      <= '0;
            r_chain_idx <= '0;
            r_word_pos  <= '0;
        end else begin
            if (i_start) begin
                r_chain_idx <= '0;
            end else if (i_advance) begin
                r_chain_idx <= r_chain_idx + CNT_W'(1);
            end
            if (i_load) begin
                r_word     <= i_data >> 1;
                r_word_pos <= '0;
            end else if (i_advance) begin
                r_word     <= r_word >> 1;
                r_word_pos <= r_word_pos + POS_W'(1);
            end
        end
    end

`ifdef BITSTREAM_LOADER_READBACK_EN
    logic [WORD_W-1:0] r_rb_shift;
    logic [WORD_W-1:0] r_rb_data;
    logic              r_rb_valid;
    logic [WORD_W-1:0] w_rb_base;
    logic [WORD_W-1:0] w_rb_next;

    // A new readback word starts clean so a partial final word has zero upper bits
    always_comb begin
        w_rb_base = (r_word_pos == '0) ? '0 : r_rb_shift;
        w_rb_next = w_rb_base | (WORD_W'(i_prog_out) << r_word_pos);
    end

    // Capture chain tail before each shift and publish full or final words
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rb_shift <= '0;
            r_rb_data  <= '0;
            r_rb_valid <= 1'b0;
        end else begin
            r_rb_valid <= 1'b0;
            if (i_capture) begin
                r_rb_shift <= w_rb_next;
                if (o_word_last_c || o_chain_last_c) begin
                    r_rb_data  <= w_rb_next;
                    r_rb_valid <= 1'b1;
                end
            end
        end
    end

    assign o_rb_data  = r_rb_data;
    assign o_rb_valid = r_rb_valid;
`else
    logic w_unused_rb;

    assign w_unused_rb = i_capture ^ i_prog_out;
    assign o_rb_data   = '0;
    assign o_rb_valid  = 1'b0;
`endif

endmodule

// File: rtl/bitstream_loader.sv
// Serial configuration-chain loader: streams words LSB first into a chain
// using a registered shift clock. Readback: define BITSTREAM_LOADER_READBACK_EN.
module bitstream_loader
    import bitstream_loader_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = 24,
    parameter int unsigned WORD_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              prog_in,
    output logic              prog_clk,
    output logic              prog_en,
    input  logic              prog_out,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid
);

    state_t r_state;
    state_t w_state_next;

    logic r_busy, r_done, r_s_ready, r_prog_in, r_prog_clk, r_prog_en;
    logic w_busy_next, w_done_next, w_s_ready_next, w_prog_in_next;
    logic w_prog_clk_next, w_prog_en_next;
    logic w_xfer, w_next_bit_c, w_word_last_c, w_chain_last_c;

    assign w_xfer = r_s_ready && s_valid;

    loader_serializer #(
        .CHAIN_LEN (CHAIN_LEN),
        .WORD_W    (WORD_W)
    ) u_serializer (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_start        ((r_state == IDLE) && start),
        .i_load         (w_xfer),
        .i_data         (s_data),
        .i_advance      (r_state == FALL),
        .i_capture      (r_state == SETUP),
        .i_prog_out     (prog_out),
        .o_next_bit_c   (w_next_bit_c),
        .o_word_last_c  (w_word_last_c),
        .o_chain_last_c (w_chain_last_c),
        .o_rb_data      (rb_data),
        .o_rb_valid     (rb_valid)
    );

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_s_ready  <= 1'b0;
            r_prog_in  <= 1'b0;
            r_prog_clk <= 1'b0;
            r_prog_en  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_busy     <= w_busy_next;
            r_done     <= w_done_next;
            r_s_ready  <= w_s_ready_next;
            r_prog_in  <= w_prog_in_next;
            r_prog_clk <= w_prog_clk_next;
            r_prog_en  <= w_prog_en_next;
        end
    end

    // Next state; outputs decoded from the next state so they line up with it
    always_comb begin
        w_state_next   = r_state;
        w_prog_in_next = r_prog_in;
        case (r_state)
            IDLE:  if (start) w_state_next = LOAD;
            LOAD: begin
                if (w_xfer) begin
                    w_state_next   = SETUP;
                    w_prog_in_next = w_next_bit_c;
                end
            end
            SETUP: w_state_next = PULSE;
            PULSE: w_state_next = FALL;
            FALL: begin
                if (w_chain_last_c) begin
                    w_state_next = DONE;
                end else if (w_word_last_c) begin
                    w_state_next = LOAD;
                end else begin
                    w_state_next   = SETUP;
                    w_prog_in_next = w_next_bit_c;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
        w_busy_next     = (w_state_next == LOAD) || (w_state_next == SETUP) ||
                          (w_state_next == PULSE) || (w_state_next == FALL);
        w_prog_en_next  = w_busy_next;
        w_s_ready_next  = (w_state_next == LOAD);
        w_prog_clk_next = (w_state_next == PULSE);
        w_done_next     = (w_state_next == DONE);
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign s_ready  = r_s_ready;
    assign prog_in  = r_prog_in;
    assign prog_clk = r_prog_clk;
    assign prog_en  = r_prog_en;

endmodule

// File: tb/tb_bitstream_loader.sv
// Bench for bitstream_loader: two instances (24-bit and 20-bit chains), each
// driving a shift-register chain model; checks against a bench reference model.
`timescale 1ns/1ps
module tb_bitstream_loader;

    localparam int unsigned WW = 8;
    localparam int unsigned LA = 24;
    localparam int unsigned LB = 20;

    logic          clk     = 1'b0;
    logic          rst     = 1'b1;
    logic          start   = 1'b0;
    logic          sel     = 1'b0;
    logic [WW-1:0] s_data  = '0;
    logic          s_valid = 1'b0;

    logic a_start, a_busy, a_done, a_s_ready, a_prog_in, a_prog_clk, a_prog_en, a_prog_out, a_rb_valid;
    logic b_start, b_busy, b_done, b_s_ready, b_prog_in, b_prog_clk, b_prog_en, b_prog_out, b_rb_valid;
    logic [WW-1:0] a_rb_data, b_rb_data;

    logic [LA-1:0] chain_a = 24'hA5C33C;
    logic [LB-1:0] chain_b = 20'h5A96E;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    assign a_start = start & ~sel;
    assign b_start = start & sel;

    bitstream_loader #(.CHAIN_LEN(LA), .WORD_W(WW)) u_dut_a (
        .clk(clk), .rst(rst), .start(a_start), .busy(a_busy), .done(a_done),
        .s_data(s_data), .s_valid(s_valid), .s_ready(a_s_ready),
        .prog_in(a_prog_in), .prog_clk(a_prog_clk), .prog_en(a_prog_en),
        .prog_out(a_prog_out), .rb_data(a_rb_data), .rb_valid(a_rb_valid)
    );

    bitstream_loader #(.CHAIN_LEN(LB), .WORD_W(WW)) u_dut_b (
        .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done),
        .s_data(s_data), .s_valid(s_valid), .s_ready(b_s_ready),
        .prog_in(b_prog_in), .prog_clk(b_prog_clk), .prog_en(b_prog_en),
        .prog_out(b_prog_out), .rb_data(b_rb_data), .rb_valid(b_rb_valid)
    );

    // Target chains: shift on the rising edge of prog_clk, tail feeds prog_out
    assign a_prog_out = chain_a[LA-1];
    assign b_prog_out = chain_b[LB-1];
    always @(posedge a_prog_clk) if (a_prog_en) chain_a <= {chain_a[LA-2:0], a_prog_in};
    always @(posedge b_prog_clk) if (b_prog_en) chain_b <= {chain_b[LB-2:0], b_prog_in};

    // Observation mux for the instance under test
    logic m_busy, m_done, m_s_ready, m_prog_in, m_prog_clk, m_prog_en, m_rb_valid;
    logic [WW-1:0] m_rb_data;
    assign m_busy     = sel ? b_busy     : a_busy;
    assign m_done     = sel ? b_done     : a_done;
    assign m_s_ready  = sel ? b_s_ready  : a_s_ready;
    assign m_prog_in  = sel ? b_prog_in  : a_prog_in;
    assign m_prog_clk = sel ? b_prog_clk : a_prog_clk;
    assign m_prog_en  = sel ? b_prog_en  : a_prog_en;
    assign m_rb_valid = sel ? b_rb_valid : a_rb_valid;
    assign m_rb_data  = sel ? b_rb_data  : a_rb_data;

    int unsigned cyc = 0, edges = 0, dones = 0, xfers = 0, viol = 0;
    int unsigned busy_rise = 0, done_cyc = 0;
    logic        prev_busy = 1'b0;
    bit          q_bits[$];
    logic [WW-1:0] q_rb[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Record every chain shift and the bit presented with it
    always @(posedge m_prog_clk) begin
        edges++;
        q_bits.push_back(m_prog_in);
    end

    // Mid-cycle monitor: timing marks, handshakes, readback words, protocol rules
    always @(negedge clk) begin
        if (m_busy && !prev_busy) busy_rise = cyc;
        prev_busy = m_busy;
        if (m_done) begin
            dones++;
            done_cyc = cyc;
        end
        if (m_rb_valid) q_rb.push_back(m_rb_data);
        if (m_s_ready && s_valid) xfers++;
        if ((m_busy !== m_prog_en) || (m_s_ready && m_prog_clk)) viol++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Readback word k expected from the chain contents before the load
    function automatic logic [WW-1:0] exp_rb(input logic [23:0] snap, input int L, input int k);
        logic [WW-1:0] r;
        r = '0;
        for (int j = 0; j < int'(WW); j++)
            if (k * int'(WW) + j < L) r[j] = snap[L - 1 - (k * int'(WW) + j)];
        return r;
    endfunction

    // Start a load and feed three words, optionally stalling or re-pulsing start
    task automatic run_load(input logic [23:0] wv, input int sw, input int sc, input bit poke);
        int t;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (poke && i == 1) begin
                start = 1'b1; @(negedge clk); start = 1'b0;
            end
            t = 0;
            while (!m_s_ready && t < 300) begin @(negedge clk); t++; end
            check("s_ready_wait", 32'(m_s_ready), 32'd1);
            if (i == sw) repeat (sc) @(negedge clk);
            s_data  = wv[i*8 +: 8];
            s_valid = 1'b1;
            @(negedge clk);
            s_valid = 1'b0;
        end
        t = 0;
        while (dones == 0 || done_cyc < busy_rise) begin
            if (t >= 400) break;
            @(negedge clk); t++;
        end
    endtask

    int unsigned rb_base = 0;

    task automatic load_and_check(input logic [23:0] wv, input int sw, input int sc, input bit poke);
        int L;
        logic [23:0] snap;
        int unsigned e0, d0, x0, v0, q0, r0;
        logic [31:0] obs, expv;
        L    = sel ? int'(LB) : int'(LA);
        snap = sel ? 24'(chain_b) : chain_a;
        e0 = edges; d0 = dones; x0 = xfers; v0 = viol;
        q0 = q_bits.size(); r0 = q_rb.size();
        run_load(wv, sw, sc, poke);
        check("shift_count", 32'(edges - e0), 32'(L));
        obs = '0;
        for (int k = 0; k < L && q0 + k < q_bits.size(); k++) obs[k] = q_bits[q0 + k];
        expv = 32'(wv) & ((32'd1 << L) - 32'd1);
        check("prog_in_seq", obs, expv);
        check("done_latency", 32'(done_cyc - busy_rise), 32'(3 + 3 * L + sc));
        check("done_count", 32'(dones - d0), 32'd1);
        check("words_taken", 32'(xfers - x0), 32'd3);
        check("protocol", 32'(viol - v0), 32'd0);
`ifdef BITSTREAM_LOADER_READBACK_EN
        check("rb_count", 32'(q_rb.size() - r0), 32'd3);
        for (int k = 0; k < 3; k++)
            if (r0 + k < q_rb.size()) check("rb_word", 32'(q_rb[r0 + k]), 32'(exp_rb(snap, L, k)));
`else
        check("rb_count", 32'(q_rb.size() - r0), 32'd0);
        check("rb_data_tied", 32'(m_rb_data), 32'd0);
`endif
        rb_base = r0;
    endtask

    initial begin
        int t;
        int unsigned e0, x0;
        @(negedge clk);
        check("reset_outs_a", 32'({a_busy, a_done, a_s_ready, a_prog_in, a_prog_clk, a_prog_en, a_rb_valid}), 32'd0);
        check("reset_rb_a", 32'(a_rb_data), 32'd0);
        check("reset_busy_b", 32'(b_busy), 32'd0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        check("idle_ready", 32'({a_busy, a_s_ready}), 32'd0);

        // Directed load, then readback of that pattern
        load_and_check(24'h015540, -1, 0, 1'b0);
        load_and_check(24'h000000, -1, 0, 1'b0);
`ifdef BITSTREAM_LOADER_READBACK_EN
        if (rb_base + 2 < q_rb.size()) begin
            check("rb_0x40", 32'(q_rb[rb_base]),     32'h40);
            check("rb_0x55", 32'(q_rb[rb_base + 1]), 32'h55);
            check("rb_0x01", 32'(q_rb[rb_base + 2]), 32'h01);
        end
`endif
        // Ten-cycle stall before word two
        load_and_check(24'($urandom), 1, 10, 1'b0);

        // start re-pulsed mid-load must be ignored
        load_and_check(24'($urandom), -1, 0, 1'b1);
        repeat (3) begin
            @(negedge clk);
            check("no_restart", 32'(a_busy), 32'd0);
        end

        // Reset during the PULSE of bit 10
        e0 = edges;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            t = 0;
            while (!a_s_ready && t < 300) begin @(negedge clk); t++; end
            s_data = 8'($urandom); s_valid = 1'b1;
            @(negedge clk); s_valid = 1'b0;
        end
        t = 0;
        while (edges - e0 < 11 && t < 300) begin @(posedge clk); #1; t++; end
        check("reach_bit10", 32'(edges - e0), 32'd11);
        rst = 1'b1;
        #1;
        check("rst_outs", 32'({a_busy, a_done, a_s_ready, a_prog_in, a_prog_clk, a_prog_en, a_rb_valid}), 32'd0);
        check("rst_rb", 32'(a_rb_data), 32'd0);
        @(negedge clk); @(negedge clk); rst = 1'b0;
        x0 = xfers;
        s_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("post_rst_idle", 32'({a_busy, a_s_ready}), 32'd0);
        end
        s_valid = 1'b0;
        check("post_rst_xfers", 32'(xfers - x0), 32'd0);

        // 20-bit chain: partial final word
        sel = 1'b1;
        @(negedge clk);
        load_and_check(24'($urandom), -1, 0, 1'b0);
        load_and_check(24'($urandom), 2, 3, 1'b0);
`ifdef BITSTREAM_LOADER_READBACK_EN
        if (rb_base + 2 < q_rb.size())
            check("rb_partial_upper", 32'(q_rb[rb_base + 2] >> 4), 32'd0);
`endif

        // Random loads with random stalls on the 24-bit chain
        sel = 1'b0;
        @(negedge clk);
        for (int n = 0; n < 4; n++)
            load_and_check(24'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 6)), 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
